// File: rtl/sigmon_event_counters.sv
// sigmon_event_counters
// Sixteen saturating event counters fed from per-CLB strobes and CLB output
// rising edges, with an atomic snapshot into shadow registers and a simple
// request/acknowledge read port over the shadow, overflow and snapshot count.
//
// Read handshake: the requester raises rd_req with rd_addr stable and holds it
// until it sees rd_ack. The block accepts only in IDLE, pulses rd_ack for one
// cycle, then waits for rd_req to drop before it can accept again, so a held
// request produces exactly one ack. rd_data stays at the value latched on
// acceptance until the next accepted read.
module sigmon_event_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cnt_enable,
  input  logic             cnt_clear,
  input  logic             snapshot_req,
  input  logic [2:0]       clb0_events_out,
  input  logic [2:0]       clb1_events_out,
  input  logic [2:0]       clb2_events_out,
  input  logic [2:0]       clb3_events_out,
  input  logic [3:0]       clbs_out,
  input  logic             rd_req,
  input  logic [4:0]       rd_addr,
  output logic             rd_ack,
  output logic [CNT_W-1:0] rd_data,
  output logic [15:0]      cnt_ovf,
  output logic [1:0]       rd_state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2
  } rd_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [11:0]      r_clb_ev;
  logic [3:0]       r_clbs;
  logic [3:0]       r_clbs_prev;
  logic [15:0]      w_ev;
  logic [CNT_W-1:0] r_cnt [16];
  logic [CNT_W-1:0] r_shadow [16];
  logic [CNT_W-1:0] r_snap_cnt;
  logic [15:0]      r_ovf;
  logic [CNT_W-1:0] w_ovf_ext;
  logic [CNT_W-1:0] w_rd_mux;
  rd_state_t        r_rd_state;
  logic             r_rd_ack;
  logic [CNT_W-1:0] r_rd_data;

  // Register all event sources once; keep the previous CLB output sample for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clb_ev    <= '0;
      r_clbs      <= '0;
      r_clbs_prev <= '0;
    end else begin
      r_clb_ev    <= {clb3_events_out, clb2_events_out, clb1_events_out, clb0_events_out};
      r_clbs      <= clbs_out;
      r_clbs_prev <= r_clbs;
    end
  end

  assign w_ev = {r_clbs & ~r_clbs_prev, r_clb_ev};

  // Live counters: clear wins over increment; at saturation the count holds and the flag sticks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) r_cnt[i] <= '0;
      r_ovf <= '0;
    end else if (cnt_clear) begin
      for (int i = 0; i < 16; i++) r_cnt[i] <= '0;
      r_ovf <= '0;
    end else if (cnt_enable) begin
      for (int i = 0; i < 16; i++) begin
        if (w_ev[i]) begin
          if (r_cnt[i] == CNT_MAX) r_ovf[i] <= 1'b1;
          else                     r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Snapshot copies the pre-edge live values, so a coincident clear or increment is not seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) r_shadow[i] <= '0;
      r_snap_cnt <= '0;
    end else if (snapshot_req) begin
      for (int i = 0; i < 16; i++) r_shadow[i] <= r_cnt[i];
      r_snap_cnt <= r_snap_cnt + CNT_ONE;
    end
  end

  // Overflow flags as a read word: zero-extended, or truncated when the counters are narrower.
  generate
    if (CNT_W > 16) begin : g_ovf_wide
      assign w_ovf_ext = {{(CNT_W-16){1'b0}}, r_ovf};
    end else if (CNT_W == 16) begin : g_ovf_eq
      assign w_ovf_ext = r_ovf;
    end else begin : g_ovf_narrow
      assign w_ovf_ext = r_ovf[CNT_W-1:0];
    end
  endgenerate

  // Read address decode: shadow bank, overflow word, snapshot count, zeros elsewhere.
  always_comb begin
    w_rd_mux = '0;
    if (!rd_addr[4])           w_rd_mux = r_shadow[rd_addr[3:0]];
    else if (rd_addr == 5'd16) w_rd_mux = w_ovf_ext;
    else if (rd_addr == 5'd17) w_rd_mux = r_snap_cnt;
  end

  // Read FSM: accept in IDLE, one-cycle ack, then wait for the request to drop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_state <= ST_IDLE;
      r_rd_ack   <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      case (r_rd_state)
        ST_IDLE: begin
          r_rd_ack <= 1'b0;
          if (rd_req) begin
            r_rd_data  <= w_rd_mux;
            r_rd_ack   <= 1'b1;
            r_rd_state <= ST_ACK;
          end
        end
        ST_ACK: begin
          r_rd_ack   <= 1'b0;
          r_rd_state <= ST_HOLD;
        end
        ST_HOLD: begin
          r_rd_ack <= 1'b0;
          if (!rd_req) r_rd_state <= ST_IDLE;
        end
        default: begin
          r_rd_ack   <= 1'b0;
          r_rd_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rd_ack       = r_rd_ack;
  assign rd_data      = r_rd_data;
  assign cnt_ovf      = r_ovf;
  assign rd_state_dbg = r_rd_state;

endmodule

// File: tb/tb_sigmon_event_counters.sv
// Directed bench for sigmon_event_counters. Two instances share all inputs:
// a default 32-bit one and a 4-bit one used to exercise saturation.
module tb_sigmon_event_counters;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cnt_enable = 1'b0;
  logic        cnt_clear = 1'b0;
  logic        snapshot_req = 1'b0;
  logic [2:0]  clb0 = '0, clb1 = '0, clb2 = '0, clb3 = '0;
  logic [3:0]  clbs_out = '0;
  logic        rd_req = 1'b0;
  logic [4:0]  rd_addr = '0;

  logic        rd_ack32, rd_ack4;
  logic [31:0] rd_data32;
  logic [3:0]  rd_data4;
  logic [15:0] ovf32, ovf4;
  logic [1:0]  st32, st4;

  int n_total = 0;
  int n_bad   = 0;
  logic [3:0] last_rd4;
  int acks;

  sigmon_event_counters #(.CNT_W(32)) u_dut32 (
    .clk(clk), .reset(reset), .cnt_enable(cnt_enable), .cnt_clear(cnt_clear),
    .snapshot_req(snapshot_req), .clb0_events_out(clb0), .clb1_events_out(clb1),
    .clb2_events_out(clb2), .clb3_events_out(clb3), .clbs_out(clbs_out),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack32), .rd_data(rd_data32),
    .cnt_ovf(ovf32), .rd_state_dbg(st32)
  );

  sigmon_event_counters #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .cnt_enable(cnt_enable), .cnt_clear(cnt_clear),
    .snapshot_req(snapshot_req), .clb0_events_out(clb0), .clb1_events_out(clb1),
    .clb2_events_out(clb2), .clb3_events_out(clb3), .clbs_out(clbs_out),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack4), .rd_data(rd_data4),
    .cnt_ovf(ovf4), .rd_state_dbg(st4)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_snap();
    snapshot_req = 1'b1;
    tick();
    snapshot_req = 1'b0;
  endtask

  // full read: ack must appear right after the accepting edge and last one cycle
  task automatic do_read(input logic [4:0] a, input string tag, input logic [31:0] exp32);
    rd_req  = 1'b1;
    rd_addr = a;
    tick();
    chk({tag, "_ack"}, {31'b0, rd_ack32}, 32'd1);
    chk(tag, rd_data32, exp32);
    last_rd4 = rd_data4;
    rd_req = 1'b0;
    tick();
    chk({tag, "_ack_end"}, {31'b0, rd_ack32}, 32'd0);
    tick();
  endtask

  initial begin
    // reset state
    idle(2);
    chk("rst_ack", {31'b0, rd_ack32}, 32'd0);
    chk("rst_data", rd_data32, 32'd0);
    chk("rst_ovf", {16'b0, ovf32}, 32'd0);
    chk("rst_state", {30'b0, st32}, 32'd0);
    reset = 1'b1;
    idle(2);

    // ten cycles of clb0 bit0
    cnt_enable = 1'b1;
    clb0 = 3'b001;
    idle(10);
    clb0 = 3'b000;
    idle(3);
    pulse_snap();
    do_read(5'd0, "a_cnt0", 32'd10);
    chk("a_cnt0_w4", {28'b0, last_rd4}, 32'd10);
    do_read(5'd16, "a_ovf", 32'd0);
    do_read(5'd17, "a_snap", 32'd1);

    // one rising edge on clbs_out[2] held 20 cycles
    clbs_out = 4'b0100;
    idle(20);
    clbs_out = 4'b0000;
    idle(3);
    pulse_snap();
    do_read(5'd14, "b_edge", 32'd1);
    do_read(5'd0, "b_cnt0", 32'd10);
    do_read(5'd25, "b_rsvd", 32'd0);
    do_read(5'd17, "b_snap", 32'd2);

    // ev[5] for 20 cycles: 4-bit counter saturates at 15 and flags overflow
    clb1 = 3'b100;
    idle(20);
    clb1 = 3'b000;
    idle(3);
    pulse_snap();
    do_read(5'd5, "c_cnt5", 32'd20);
    chk("c_sat_w4", {28'b0, last_rd4}, 32'd15);
    chk("c_ovf_w4", {16'b0, ovf4}, 32'h0020);
    chk("c_ovf_w32", {16'b0, ovf32}, 32'd0);
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    chk("c_ovf_clr_w4", {16'b0, ovf4}, 32'd0);
    idle(2);
    pulse_snap();
    do_read(5'd16, "c_ovf_rd", 32'd0);
    do_read(5'd5, "c_cnt5_clr", 32'd0);
    do_read(5'd0, "c_cnt0_clr", 32'd0);

    // counter 7: snapshot and clear on the same edge
    clb2 = 3'b010;
    idle(6);
    clb2 = 3'b000;
    idle(3);
    cnt_clear = 1'b1;
    snapshot_req = 1'b1;
    tick();
    cnt_clear = 1'b0;
    snapshot_req = 1'b0;
    do_read(5'd7, "d_preclr", 32'd6);
    clb2 = 3'b010;
    idle(4);
    clb2 = 3'b000;
    idle(3);
    pulse_snap();
    do_read(5'd7, "d_postclr", 32'd4);
    // events with enable low are ignored
    cnt_enable = 1'b0;
    clb2 = 3'b010;
    idle(5);
    clb2 = 3'b000;
    idle(3);
    pulse_snap();
    do_read(5'd7, "d_noen", 32'd4);
    cnt_enable = 1'b1;

    // held request: one ack, data held across a snapshot
    rd_req  = 1'b1;
    rd_addr = 5'd17;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) snapshot_req = 1'b1;
      if (i == 3) snapshot_req = 1'b0;
      tick();
      if (rd_ack32) acks++;
    end
    chk("e_one_ack", acks, 32'd1);
    chk("e_data_held", rd_data32, 32'd7);
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rd_ack32) acks++;
    end
    chk("e_no_reack", acks, 32'd0);
    chk("e_hold_state", {30'b0, st32}, 32'd2);
    rd_req = 1'b0;
    idle(2);
    chk("e_idle_state", {30'b0, st32}, 32'd0);
    do_read(5'd17, "e_snap", 32'd8);

    // reset during ACK
    rd_req  = 1'b1;
    rd_addr = 5'd17;
    tick();
    chk("f_ack_pre", {31'b0, rd_ack32}, 32'd1);
    chk("f_data_pre", rd_data32, 32'd8);
    reset = 1'b0;
    #1;
    chk("f_ack_rst", {31'b0, rd_ack32}, 32'd0);
    chk("f_data_rst", rd_data32, 32'd0);
    chk("f_state_rst", {30'b0, st32}, 32'd0);
    rd_req   = 1'b0;
    clbs_out = 4'b0001;
    idle(2);
    reset = 1'b1;
    idle(2);
    do_read(5'd17, "f_snap", 32'd0);
    do_read(5'd0, "f_cnt0", 32'd0);
    do_read(5'd7, "f_cnt7", 32'd0);
    do_read(5'd16, "f_ovf", 32'd0);
    // clbs_out[0] high out of reset counts exactly once
    pulse_snap();
    do_read(5'd12, "f_edge_rst", 32'd1);
    do_read(5'd17, "f_snap1", 32'd1);
    clbs_out = 4'b0000;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
